// File: rtl/ysyx_23060191_mem_arbiter.sv
// Two-master (IFU = m0, LSU = m1) arbiter sharing one SRAM-like slave port, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin on contention; otherwise the LSU has fixed priority.
module ysyx_23060191_mem_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req_valid,
  output logic            m0_req_ready,
  input  logic [AW-1:0]   m0_addr,
  output logic            m0_resp_valid,
  input  logic            m0_resp_ready,
  output logic [DW-1:0]   m0_rdata,
  input  logic            m1_req_valid,
  output logic            m1_req_ready,
  input  logic [AW-1:0]   m1_addr,
  input  logic            m1_wen,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_wmask,
  output logic            m1_resp_valid,
  input  logic            m1_resp_ready,
  output logic [DW-1:0]   m1_rdata,
  output logic            s_req_valid,
  input  logic            s_req_ready,
  output logic [AW-1:0]   s_addr,
  output logic            s_wen,
  output logic [DW-1:0]   s_wdata,
  output logic [DW/8-1:0] s_wmask,
  input  logic            s_resp_valid,
  output logic            s_resp_ready,
  input  logic [DW-1:0]   s_rdata
);

  localparam int unsigned MW = DW / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   gnt_q, gnt_d;
  logic   pick;
  logic   gnt_req_valid;
  logic   gnt_resp_ready;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_gnt_q, last_gnt_d;

  // Contention goes to whoever was not served last; a lone requester always wins.
  always_comb begin
    pick = m1_req_valid;
    if (m0_req_valid && m1_req_valid) begin
      pick = ~last_gnt_q;
    end
  end
`else
  // LSU wins contention so the memory stage drains before the next fetch.
  always_comb begin
    pick = m1_req_valid;
  end
`endif

  assign gnt_req_valid  = gnt_q ? m1_req_valid  : m0_req_valid;
  assign gnt_resp_ready = gnt_q ? m1_resp_ready : m0_resp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_gnt_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_gnt_q <= last_gnt_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_gnt_d    = last_gnt_q;
`endif
    m0_req_ready  = 1'b0;
    m1_req_ready  = 1'b0;
    m0_resp_valid = 1'b0;
    m1_resp_valid = 1'b0;
    m0_rdata      = '0;
    m1_rdata      = '0;
    s_req_valid   = 1'b0;
    s_addr        = '0;
    s_wen         = 1'b0;
    s_wdata       = '0;
    s_wmask       = MW'(0);
    s_resp_ready  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (m0_req_valid || m1_req_valid) begin
          gnt_d   = pick;
          state_d = REQ;
        end
      end

      REQ: begin
        s_req_valid = gnt_req_valid;
        if (gnt_q) begin
          s_addr       = m1_addr;
          s_wen        = m1_wen;
          s_wdata      = m1_wdata;
          s_wmask      = m1_wmask;
          m1_req_ready = s_req_ready;
        end else begin
          s_addr       = m0_addr;
          m0_req_ready = s_req_ready;
        end
        // A granted master that withdraws its request abandons the slot.
        if (!gnt_req_valid) begin
          state_d = IDLE;
        end else if (s_req_ready) begin
          state_d = RESP;
        end
      end

      RESP: begin
        s_resp_ready = gnt_resp_ready;
        if (gnt_q) begin
          m1_resp_valid = s_resp_valid;
          m1_rdata      = s_rdata;
        end else begin
          m0_resp_valid = s_resp_valid;
          m0_rdata      = s_rdata;
        end
        if (s_resp_valid && gnt_resp_ready) begin
`ifdef ARB_ROUND_ROBIN_EN
          last_gnt_d = gnt_q;
`endif
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060191_mem_arbiter.sv
// Self-checking bench for ysyx_23060191_mem_arbiter: vector table, directed corner cases, random rounds.
`timescale 1ns/1ps
module tb_ysyx_23060191_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = DW / 8;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req_valid, m0_req_ready, m0_resp_valid, m0_resp_ready;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_rdata;
  logic          m1_req_valid, m1_req_ready, m1_wen, m1_resp_valid, m1_resp_ready;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [MW-1:0] m1_wmask;
  logic          s_req_valid, s_req_ready, s_wen, s_resp_valid, s_resp_ready;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [MW-1:0] s_wmask;

  ysyx_23060191_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
    .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready), .m0_rdata(m0_rdata),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
    .m1_wen(m1_wen), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready), .m1_rdata(m1_rdata),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_addr(s_addr),
    .s_wen(s_wen), .s_wdata(s_wdata), .s_wmask(s_wmask),
    .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  // One master transaction plus its stall profile (slave req/resp wait, master resp wait).
  typedef struct {
    logic [AW-1:0] addr;
    logic          wen;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
    logic [DW-1:0] rdata;
    int            rq, rs, mr;
  } txn_t;

  typedef struct {
    int            m;
    logic [AW-1:0] addr;
    logic          wen;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
    logic [DW-1:0] rdata;
    int            rq, rs, mr;
    logic          exp_swen;
    logic [MW-1:0] exp_swmask;
    logic [DW-1:0] exp_rdata;
    int            exp_cycles;
  } vec_t;

  int            checks = 0;
  int            failures = 0;
  txn_t          tx [2];
  int            n_left [2];
  int            last_m;
  int            order [$];
  logic          cap_swen;
  logic [MW-1:0] cap_swmask;
  logic [DW-1:0] cap_rdata;
  int            cap_cycles;
  vec_t          vec [6];
  int            exp_ord [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic quiet(input bit full, input string tag);
    chk({tag, ".valid_ready"}, {s_req_valid, s_resp_ready, m0_req_ready, m1_req_ready,
                                m0_resp_valid, m1_resp_valid}, 64'd0);
    if (full) begin
      chk({tag, ".s_addr"}, s_addr, 64'd0);
      chk({tag, ".s_wen_wmask"}, {s_wen, s_wmask}, 64'd0);
      chk({tag, ".s_wdata"}, s_wdata, 64'd0);
      chk({tag, ".m_rdata"}, {m0_rdata, m1_rdata}, 64'd0);
    end
  endtask

  task automatic drive_zero();
    m0_req_valid = 1'b0; m0_addr = '0; m0_resp_ready = 1'b0;
    m1_req_valid = 1'b0; m1_addr = '0; m1_wen = 1'b0; m1_wdata = '0; m1_wmask = '0;
    m1_resp_ready = 1'b0;
    s_req_ready = 1'b0; s_resp_valid = 1'b0; s_rdata = '0;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b1;
    drive_zero();
    repeat (n) @(posedge clk);
    @(negedge clk);
    quiet(1'b1, "reset");
    @(posedge clk); #1;
    rst = 1'b0;
    last_m = 1;
  endtask

  task automatic idle_gap(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      m0_req_valid = 1'b0;
      m1_req_valid = 1'b0;
      s_req_ready = 1'($urandom);
      s_resp_valid = 1'b0;
      @(negedge clk);
      quiet(1'b0, "gap");
    end
  endtask

  // Spec priority rule: round-robin picks the master not served last; fixed picks the LSU.
  function automatic int pick_model(input bit l0, input bit l1, input int last);
    if (l0 && l1) return RR_EN ? ((last == 0) ? 1 : 0) : 1;
    return l1 ? 1 : 0;
  endfunction

  task automatic rand_tx(input int m);
    tx[m].addr  = $urandom & 32'hFFFF_FFFC;
    tx[m].wen   = 1'($urandom);
    tx[m].wdata = $urandom;
    tx[m].wmask = MW'($urandom);
    tx[m].rdata = $urandom;
    tx[m].rq    = int'($urandom_range(0, 3));
    tx[m].rs    = int'($urandom_range(0, 3));
    tx[m].mr    = int'($urandom_range(0, 3));
  endtask

  // Serve all outstanding transactions in n_left[], playing both masters and the slave.
  task automatic run_txns(input int budget);
    int w, cyc, arb_ph, rqw, rsw, mrw;
    bit in_resp;
    w = pick_model(n_left[0] > 0, n_left[1] > 0, last_m);
    rqw = tx[w].rq; rsw = tx[w].rs; mrw = tx[w].mr;
    in_resp = 1'b0; arb_ph = 0; cyc = 0;
    while (n_left[0] > 0 || n_left[1] > 0) begin
      if (cyc >= budget) begin
        checks++; failures++;
        $display("FAIL timeout: got %0d cycles without completion, expected under %0d", cyc, budget);
        break;
      end
      @(posedge clk); #1;
      m0_req_valid  = (n_left[0] > 0) && !(in_resp && w == 0);
      m1_req_valid  = (n_left[1] > 0) && !(in_resp && w == 1);
      m0_addr       = tx[0].addr;
      m1_addr       = tx[1].addr;
      m1_wen        = tx[1].wen;
      m1_wdata      = tx[1].wdata;
      m1_wmask      = tx[1].wmask;
      s_req_ready   = (!in_resp && arb_ph == 1) ? (rqw == 0) : 1'($urandom);
      s_resp_valid  = in_resp && (rsw == 0);
      s_rdata       = in_resp ? tx[w].rdata : $urandom;
      m0_resp_ready = (in_resp && w == 0) ? (mrw == 0) : 1'($urandom);
      m1_resp_ready = (in_resp && w == 1) ? (mrw == 0) : 1'($urandom);
      @(negedge clk);
      cyc++;
      if (arb_ph == 0) begin
        quiet(1'b0, "arb");
        arb_ph = 1;
      end else if (!in_resp) begin
        chk("req.s_req_valid", s_req_valid, 64'd1);
        chk("req.s_addr", s_addr, tx[w].addr);
        chk("req.s_wen", s_wen, (w == 1) ? tx[1].wen : 1'b0);
        chk("req.s_wmask", s_wmask, (w == 1) ? tx[1].wmask : MW'(0));
        if (w == 1) chk("req.s_wdata", s_wdata, tx[1].wdata);
        chk("req.gnt_ready", (w == 0) ? m0_req_ready : m1_req_ready, s_req_ready);
        chk("req.other_ready", (w == 0) ? m1_req_ready : m0_req_ready, 64'd0);
        chk("req.resp_side", {m0_resp_valid, m1_resp_valid, s_resp_ready}, 64'd0);
        if (s_req_ready) begin
          in_resp = 1'b1;
          cap_swen = s_wen;
          cap_swmask = s_wmask;
        end else if (rqw > 0) begin
          rqw--;
        end
      end else begin
        chk("resp.req_side", {s_req_valid, m0_req_ready, m1_req_ready}, 64'd0);
        chk("resp.gnt_valid", (w == 0) ? m0_resp_valid : m1_resp_valid, s_resp_valid);
        chk("resp.other_valid", (w == 0) ? m1_resp_valid : m0_resp_valid, 64'd0);
        chk("resp.gnt_rdata", (w == 0) ? m0_rdata : m1_rdata, tx[w].rdata);
        chk("resp.s_resp_ready", s_resp_ready, (w == 0) ? m0_resp_ready : m1_resp_ready);
        if (s_resp_valid && ((w == 0) ? m0_resp_ready : m1_resp_ready)) begin
          cap_rdata = (w == 0) ? m0_rdata : m1_rdata;
          cap_cycles = cyc;
          order.push_back(w);
          last_m = w;
          n_left[w]--;
          if (n_left[w] > 0) rand_tx(w);
          in_resp = 1'b0;
          arb_ph = 0;
          if (n_left[0] > 0 || n_left[1] > 0) begin
            w = pick_model(n_left[0] > 0, n_left[1] > 0, last_m);
            rqw = tx[w].rq; rsw = tx[w].rs; mrw = tx[w].mr;
          end
        end else begin
          if (rsw > 0) rsw--;
          if (mrw > 0) mrw--;
        end
      end
    end
  endtask

  initial begin
    //            m  addr           wen   wdata          wmask  rdata          rq rs mr swen  swmask exp_rdata     cyc
    vec[0] = '{0, 32'h8000_0000, 1'b0, 32'h0,         4'h0, 32'h0010_0073, 0, 0, 0, 1'b0, 4'h0, 32'h0010_0073, 3};
    vec[1] = '{1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0,         0, 0, 0, 1'b1, 4'hF, 32'h0,         3};
    vec[2] = '{1, 32'h8000_2004, 1'b0, 32'h1234_5678, 4'h0, 32'hCAFE_F00D, 0, 0, 0, 1'b0, 4'h0, 32'hCAFE_F00D, 3};
    vec[3] = '{0, 32'h8000_0040, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0000_0513, 5, 3, 2, 1'b0, 4'h0, 32'h0000_0513, 11};
    vec[4] = '{1, 32'h8000_3008, 1'b1, 32'hA5A5_5A5A, 4'h5, 32'h0,         1, 0, 2, 1'b1, 4'h5, 32'h0,         6};
    vec[5] = '{1, 32'h8000_400C, 1'b0, 32'h0,         4'h0, 32'h7777_0001, 2, 2, 0, 1'b0, 4'h0, 32'h7777_0001, 7};
    if (RR_EN) exp_ord = '{0, 1, 0, 1};
    else       exp_ord = '{1, 1, 0, 0};

    drive_zero();
    last_m = 1;
    do_reset(3);
    idle_gap(4);
    @(negedge clk);
    quiet(1'b1, "post_reset");

    // Single-master vectors, including the stalled case
    for (int i = 0; i < 6; i++) begin
      rand_tx(0);
      rand_tx(1);
      tx[vec[i].m] = '{vec[i].addr, vec[i].wen, vec[i].wdata, vec[i].wmask, vec[i].rdata,
                       vec[i].rq, vec[i].rs, vec[i].mr};
      n_left[0] = (vec[i].m == 0) ? 1 : 0;
      n_left[1] = (vec[i].m == 1) ? 1 : 0;
      run_txns(100);
      chk($sformatf("vec%0d.s_wen", i), cap_swen, vec[i].exp_swen);
      chk($sformatf("vec%0d.s_wmask", i), cap_swmask, vec[i].exp_swmask);
      if (!vec[i].wen || vec[i].m == 0) chk($sformatf("vec%0d.rdata", i), cap_rdata, vec[i].exp_rdata);
      chk($sformatf("vec%0d.cycles", i), cap_cycles, vec[i].exp_cycles);
      idle_gap(1);
    end

    // Granted master withdraws in REQ: no slave request, then a normal LSU read
    @(posedge clk); #1;
    m0_req_valid = 1'b1; m0_addr = 32'h8000_0100; s_req_ready = 1'b1;
    @(negedge clk);
    chk("abort.idle_s_req_valid", s_req_valid, 64'd0);
    @(posedge clk); #1;
    m0_req_valid = 1'b0;
    @(negedge clk);
    chk("abort.req_s_req_valid", s_req_valid, 64'd0);
    chk("abort.m1_req_ready", m1_req_ready, 64'd0);
    rand_tx(1); tx[1].wen = 1'b0;
    n_left[0] = 0; n_left[1] = 1;
    run_txns(100);
    chk("abort.next_cycles", cap_cycles, 64'd3 + 64'(tx[1].rq) + 64'(tx[1].rs > tx[1].mr ? tx[1].rs : tx[1].mr));
    idle_gap(1);

    // Sustained contention with immediate re-requests
    do_reset(1);
    order.delete();
    rand_tx(0); rand_tx(1);
    n_left[0] = 2; n_left[1] = 2;
    run_txns(200);
    chk("contend.count", order.size(), 64'd4);
    for (int i = 0; i < 4 && i < order.size(); i++)
      chk($sformatf("contend.order%0d", i), order[i], exp_ord[i]);
    idle_gap(1);

    // Reset while the LSU is in its response phase, IFU waiting
    @(posedge clk); #1;
    m1_req_valid = 1'b1; m1_addr = 32'h8000_5000; m1_wen = 1'b0; s_req_ready = 1'b1;
    m1_resp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst6.req_handshake", {s_req_valid, m1_req_ready}, 64'd3);
    @(posedge clk); #1;
    m1_req_valid = 1'b0; s_resp_valid = 1'b0; m0_req_valid = 1'b1; m0_addr = 32'h8000_0200;
    @(negedge clk);
    chk("rst6.in_resp", {s_resp_ready, m0_req_ready, m1_req_ready}, 64'd4);
    @(posedge clk); #1;
    rst = 1'b1; s_resp_valid = 1'b1; s_rdata = 32'h5555_AAAA;
    @(negedge clk);
    quiet(1'b1, "rst6.during");
    @(posedge clk); #1;
    rst = 1'b0; last_m = 1;
    drive_zero();
    tx[0].addr = 32'h8000_0200; tx[0].rdata = 32'h0041_0113;
    tx[0].rq = 0; tx[0].rs = 0; tx[0].mr = 0;
    n_left[0] = 1; n_left[1] = 0;
    run_txns(100);
    chk("rst6.m0_rdata", cap_rdata, 64'h0041_0113);
    chk("rst6.m0_cycles", cap_cycles, 64'd3);
    idle_gap(1);

    // Random rounds against the priority model
    for (int r = 0; r < 30; r++) begin
      rand_tx(0); rand_tx(1);
      n_left[0] = int'($urandom_range(0, 2));
      n_left[1] = int'($urandom_range(0, 2));
      if (n_left[0] == 0 && n_left[1] == 0) n_left[r % 2] = 1;
      run_txns(300);
      idle_gap(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
